// File: rtl/rr_arbiter3_if.sv
// Request/grant bundle between the requesters and the three-way round-robin arbiter.
interface rr_arbiter3_if;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       preempt;

  modport master (output req, input grant, owner, busy, preempt);
  modport slave  (input req, output grant, owner, busy, preempt);
endinterface

// File: rtl/rr_arbiter3.sv
// Three-requester round-robin arbiter with bounded hold time under contention
// and one dead cycle between successive owners.
module rr_arbiter3 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter3_if.slave bus
);

  localparam int unsigned     HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state, state_d;
  logic [1:0]      ptr, ptr_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [2:0]      grant_d;
  logic [1:0]      owner_d;
  logic            busy_d, preempt_d;
  logic [1:0]      pick, cand;
  logic            pick_ok;
  logic [2:0]      others;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] x);
    return 3'b001 << x;
  endfunction

  // First requester at or after ptr, wrapping mod 3.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = ptr;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!pick_ok && bus.req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
      cand = inc3(cand);
    end
  end

  assign others = bus.req & ~onehot(bus.owner);

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    hold_d    = hold_cnt;
    grant_d   = bus.grant;
    owner_d   = bus.owner;
    busy_d    = bus.busy;
    preempt_d = bus.preempt;

    unique case (state)
      IDLE, RELEASE: begin
        preempt_d = 1'b0;
        if (pick_ok) begin
          state_d = GRANT;
          owner_d = pick;
          grant_d = onehot(pick);
          busy_d  = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[bus.owner] || (hold_cnt >= HOLD_LAST && |others)) begin
          // Timeout only when the owner still wants the resource.
          preempt_d = bus.req[bus.owner];
          state_d   = RELEASE;
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = inc3(bus.owner);
        end else if (hold_cnt < HOLD_LAST) begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      bus.grant   <= '0;
      bus.owner   <= '0;
      bus.busy    <= 1'b0;
      bus.preempt <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      hold_cnt    <= hold_d;
      bus.grant   <= grant_d;
      bus.owner   <= owner_d;
      bus.busy    <= busy_d;
      bus.preempt <= preempt_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter3.sv
// Randomised and directed bench for rr_arbiter3 against a cycle-level ownership model.
module tb_rr_arbiter3;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;
  rr_arbiter3_if bus ();

  rr_arbiter3 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: who owns the resource, for how many cycles so far, and where the search starts.
  int m_own  = -1;
  int m_held = 0;
  int m_ptr  = 0;
  int m_last = 0;
  bit m_pre  = 1'b0;

  logic [6:0] obs;
  assign obs = {bus.grant, bus.owner, bus.busy, bus.preempt};

  function automatic logic [6:0] model_out();
    logic [2:0] g;
    g = (m_own >= 0) ? 3'(3'b001 << m_own) : 3'b000;
    return {g, 2'(m_last), (m_own >= 0), m_pre};
  endfunction

  task automatic step();
    logic [2:0] r;
    logic       s;
    bit         got;
    int         c;
    r = bus.req;
    s = rst;
    @(posedge clk);
    if (!s) begin
      m_own = -1; m_held = 0; m_ptr = 0; m_last = 0; m_pre = 1'b0;
    end else if (m_own >= 0) begin
      if (!r[m_own]) begin
        m_ptr = (m_own + 1) % 3; m_own = -1; m_pre = 1'b0;
      end else if (m_held >= MAX_HOLD && (r & ~(3'b001 << m_own)) != 3'b000) begin
        m_ptr = (m_own + 1) % 3; m_own = -1; m_pre = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      m_pre = 1'b0;
      got   = 1'b0;
      for (int k = 0; k < 3; k++) begin
        c = (m_ptr + k) % 3;
        if (!got && r[c]) begin
          got = 1'b1; m_own = c; m_last = c; m_held = 1;
        end
      end
    end
    #1;
  endtask

  task automatic settle_and_reset();
    bus.req = 3'b000;
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req = 3'b111;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== 7'b000_00_0_0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got g/o/b/p=%b want 0000000", i, obs);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.grant !== 3'b001 || obs !== model_out()) begin
      failures++;
      $display("FAIL reset_first_grant got %b want %b (grant 001)", obs, model_out());
    end
  endtask

  task automatic test_single();
    bus.req = 3'b000;
    step(); step();
    bus.req = 3'b010;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (obs !== {3'b010, 2'd1, 1'b1, 1'b0} || obs !== model_out()) begin
        failures++;
        $display("FAIL single_hold edge%0d got %b want %b", i, obs, model_out());
      end
    end
    bus.req = 3'b000;
    step();
    checks++;
    if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || obs !== model_out()) begin
      failures++;
      $display("FAIL single_release got %b want %b", obs, model_out());
    end
    step();
    bus.req = 3'b001;
    step();
    checks++;
    if (bus.grant !== 3'b001 || obs !== model_out()) begin
      failures++;
      $display("FAIL single_next got %b want %b", obs, model_out());
    end
  endtask

  task automatic test_contention();
    logic [2:0] seq [16];
    logic       pre;
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
            3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
            3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
    settle_and_reset();
    bus.req = 3'b111;
    for (int i = 0; i < 16; i++) begin
      step();
      pre = (seq[i] == 3'b000);
      checks++;
      if (bus.grant !== seq[i] || bus.preempt !== pre || obs !== model_out()) begin
        failures++;
        $display("FAIL contention cyc%0d got g=%b p=%b want g=%b p=%b model=%b",
                 i, bus.grant, bus.preempt, seq[i], pre, model_out());
      end
    end
  endtask

  task automatic test_no_contention();
    settle_and_reset();
    bus.req = 3'b001;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (bus.grant !== 3'b001 || bus.preempt !== 1'b0 || obs !== model_out()) begin
        failures++;
        $display("FAIL no_contention cyc%0d got g=%b p=%b want g=001 p=0", i, bus.grant, bus.preempt);
      end
    end
    checks++;
    if (dut.hold_cnt !== 3) begin
      failures++;
      $display("FAIL hold_saturate got %0d want 3", dut.hold_cnt);
    end
  endtask

  task automatic test_wrap();
    settle_and_reset();
    bus.req = 3'b100;
    step(); step();
    bus.req = 3'b001;
    step();
    checks++;
    if (bus.grant !== 3'b000 || bus.preempt !== 1'b0 || obs !== model_out()) begin
      failures++;
      $display("FAIL wrap_dead got g=%b p=%b want g=000 p=0", bus.grant, bus.preempt);
    end
    bus.req = 3'b101;
    step();
    checks++;
    if (bus.grant !== 3'b001 || bus.owner !== 2'd0 || obs !== model_out()) begin
      failures++;
      $display("FAIL wrap_next got g=%b o=%0d want g=001 o=0", bus.grant, bus.owner);
    end
  endtask

  task automatic test_reset_mid();
    settle_and_reset();
    bus.req = 3'b100;
    step(); step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (bus.grant !== 3'b000 || bus.preempt !== 1'b0 || dut.ptr !== 2'd0 || obs !== model_out()) begin
      failures++;
      $display("FAIL reset_mid got g=%b p=%b ptr=%0d want g=000 p=0 ptr=0", bus.grant, bus.preempt, dut.ptr);
    end
    rst = 1'b1;
    bus.req = 3'b110;
    step();
    checks++;
    if (bus.grant !== 3'b010 || obs !== model_out()) begin
      failures++;
      $display("FAIL reset_mid_regrant got g=%b want g=010", bus.grant);
    end
  endtask

  task automatic test_random();
    logic [2:0] prev_req;
    settle_and_reset();
    prev_req = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      // Requests mostly persist so that holds and timeouts actually occur.
      bus.req = ($urandom_range(0, 3) == 0) ? 3'($urandom) : prev_req;
      prev_req = bus.req;
      step();
      checks++;
      if (obs !== model_out()) begin
        failures++;
        $display("FAIL random cyc%0d got %b want %b", i, obs, model_out());
      end
      checks++;
      if ((bus.grant & (bus.grant - 3'b001)) !== 3'b000 || bus.busy !== |bus.grant ||
          (bus.preempt && bus.grant !== 3'b000) || bus.owner === 2'd3) begin
        failures++;
        $display("FAIL invariant cyc%0d got g=%b b=%b p=%b o=%0d", i, bus.grant, bus.busy, bus.preempt, bus.owner);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.req = 3'b000;
    test_reset();
    test_single();
    test_contention();
    test_no_contention();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
